icache_refill: RTL

Instruction-cache refill engine: on a miss from the instruction cache it claims the shared byte-wide RAM bus and reads the 16-byte block containing the missing address. It assembles the block and presents it to the cache as a one-cycle fill pulse (`refillValid`/`refillAddr`/`refillData`). It sits between the instruction cache and the memory arbiter. It is the producing end of the cache's block-fill port.

---
 rtl/icache_refill.sv | 135 +++++++++++++
 1 files changed

// File: rtl/icache_refill.sv
// Instruction-cache refill engine: fetches the 16-byte block for a missing address over the
// byte-wide RAM bus and hands it to the cache as a one-cycle fill pulse.
// Optional build macro: ICACHE_REFILL_CRITICAL_FIRST_EN (issue the critical word first).
module icache_refill #(
    parameter int BLOCK_WIDTH = 4,
    parameter int BLOCK_SIZE  = 2 ** BLOCK_WIDTH
) (
    input  logic                      clkIn,
    input  logic                      resetIn,
    input  logic                      missIn,
    input  logic [31:0]               missAddrIn,
    input  logic                      flushIn,
    output logic                      ramReq,
    input  logic                      ramGrant,
    output logic [31:0]               ramAddrOut,
    input  logic [7:0]                ramDataIn,
    output logic                      refillValid,
    output logic [31-BLOCK_WIDTH:0]   refillAddr,
    output logic [BLOCK_SIZE*8-1:0]   refillData,
    output logic                      busy
);

    localparam int CNT_W = BLOCK_WIDTH + 1;
    localparam logic [BLOCK_WIDTH-1:0] OFF_ONE      = BLOCK_WIDTH'(1);
    localparam logic [CNT_W-1:0]       CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0]       LAST_ISSUE   = CNT_W'(BLOCK_SIZE - 1);
    localparam logic [CNT_W-1:0]       LAST_CAPTURE = CNT_W'(BLOCK_SIZE);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        READ,
        DONE
    } state_t;

    state_t                 state;
    logic [BLOCK_WIDTH-1:0] start_off;
    logic [CNT_W-1:0]       issue_cnt;   // READ cycle index, 0..BLOCK_SIZE

    logic [BLOCK_WIDTH-1:0] start_new;
    logic [BLOCK_WIDTH-1:0] next_issue_off;
    logic [BLOCK_WIDTH-1:0] capture_off;

`ifdef ICACHE_REFILL_CRITICAL_FIRST_EN
    assign start_new = {missAddrIn[BLOCK_WIDTH-1:2], 2'b00};
`else
    assign start_new = '0;
`endif

    // Low address bits only matter for the critical-first start offset.
    logic unused_miss_bits;
    assign unused_miss_bits = &{1'b0, missAddrIn[BLOCK_WIDTH-1:0]};

    // The address register runs one cycle ahead of the byte being captured: while issue_cnt = k
    // the bus carries offset start+k and ramDataIn holds the byte for offset start+k-1.
    assign next_issue_off = start_off + issue_cnt[BLOCK_WIDTH-1:0] + OFF_ONE;
    assign capture_off    = start_off + issue_cnt[BLOCK_WIDTH-1:0] - OFF_ONE;

    assign busy = (state != IDLE);

    // NOTE: every register here, including the data block, is cleared by the asynchronous reset
    // so a reset mid-refill leaves no stale fill visible to the cache.
    always_ff @(posedge clkIn or negedge resetIn) begin
        if (!resetIn) begin
            state       <= IDLE;
            start_off   <= '0;
            issue_cnt   <= '0;
            ramReq      <= 1'b0;
            ramAddrOut  <= '0;
            refillValid <= 1'b0;
            refillAddr  <= '0;
            refillData  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    refillValid <= 1'b0;
                    if (missIn && !flushIn) begin
                        refillAddr <= missAddrIn[31:BLOCK_WIDTH];
                        start_off  <= start_new;
                        ramReq     <= 1'b1;
                        state      <= REQ;
                    end
                end

                REQ: begin
                    if (flushIn) begin
                        ramReq <= 1'b0;
                        state  <= IDLE;
                    end else if (ramGrant) begin
                        issue_cnt  <= '0;
                        ramAddrOut <= {refillAddr, start_off};
                        state      <= READ;
                    end
                end

                READ: begin
                    if (flushIn) begin
                        ramReq     <= 1'b0;
                        ramAddrOut <= '0;
                        state      <= IDLE;
                    end else begin
                        issue_cnt <= issue_cnt + CNT_ONE;
                        if (issue_cnt != '0) begin
                            refillData[{capture_off, 3'b000} +: 8] <= ramDataIn;
                        end
                        if (issue_cnt < LAST_ISSUE) begin
                            ramAddrOut <= {refillAddr, next_issue_off};
                        end else begin
                            ramAddrOut <= '0;
                        end
                        if (issue_cnt == LAST_CAPTURE) begin
                            ramReq      <= 1'b0;
                            refillValid <= 1'b1;
                            state       <= DONE;
                        end
                    end
                end

                DONE: begin
                    // A flush here is ignored: the fill is address-tagged and harmless.
                    refillValid <= 1'b0;
                    state       <= IDLE;
                end

                default: begin
                    ramReq      <= 1'b0;
                    ramAddrOut  <= '0;
                    refillValid <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule
